// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the MEM-stage data-memory access controller.
// Holds funct3 encodings, FSM states, byte-enable patterns and the legality check.
package mem_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    // Unsigned widths exist only for loads; halves and words must be naturally aligned.
    function automatic logic req_legal(input logic we, input logic [2:0] f3,
                                       input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:          ok = 1'b1;
            F3_H:          ok = ~addr_lo[0];
            F3_W:          ok = (addr_lo == 2'b00);
            F3_BU:         ok = ~we;
            F3_HU:         ok = ~we & ~addr_lo[0];
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_data_ext.sv
// Load lane select and extension: picks the byte/half addressed by addr_lo out of
// the RAM word and sign- or zero-extends it according to funct3.
module load_data_ext
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] ram_rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = ram_rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = ram_rdata[7:0];
            2'd1:    byte_sel = ram_rdata[15:8];
            2'd2:    byte_sel = ram_rdata[23:16];
            default: byte_sel = ram_rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? ram_rdata[31:16] : ram_rdata[15:0];

        result = ram_rdata;
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'd0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'd0, half_sel};
            default: result = ram_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: accepts one load/store, drives a
// registered word-wide RAM port with ack handshake and timeout, returns extended load data.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        misalign,
    output logic        bus_err,
    output logic        ram_req,
    output logic        ram_we,
    output logic [3:0]  ram_be,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic        ram_ack,
    input  logic [31:0] ram_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state, state_next;
    logic              legal;
    logic              accept;
    logic              timeout;
    logic [CNT_W-1:0]  wait_cnt;
    logic [2:0]        f3_q;
    logic [1:0]        addr_lo_q;
    logic [3:0]        be_calc;
    logic [31:0]       wdata_calc;
    logic [31:0]       ld_ext;

    assign legal   = req_legal(req_we, req_funct3, req_addr[1:0]);
    assign timeout = (state == ST_BUSY) && !ram_ack && (wait_cnt == CNT_LAST);

    always_comb begin
        be_calc    = BE_W;
        wdata_calc = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                be_calc    = BE_B << req_addr[1:0];
                wdata_calc = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_calc    = BE_H << req_addr[1:0];
                wdata_calc = {2{req_wdata[15:0]}};
            end
            default: begin
                be_calc    = BE_W;
                wdata_calc = req_wdata;
            end
        endcase
    end

    load_data_ext u_ext (
        .ram_rdata (ram_rdata),
        .funct3    (f3_q),
        .addr_lo   (addr_lo_q),
        .result    (ld_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // stall/misalign are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        misalign   = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid && rst_n) begin
                    if (legal) begin
                        accept     = 1'b1;
                        stall      = 1'b1;
                        state_next = ST_BUSY;
                    end else begin
                        misalign = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (ram_ack || timeout) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_req     <= 1'b0;
            ram_we      <= 1'b0;
            ram_be      <= '0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
            wait_cnt    <= '0;
            f3_q        <= '0;
            addr_lo_q   <= '0;
        end else begin
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
            if (accept) begin
                ram_req   <= 1'b1;
                ram_we    <= req_we;
                ram_be    <= be_calc;
                ram_addr  <= req_addr[31:2];
                ram_wdata <= wdata_calc;
                f3_q      <= req_funct3;
                addr_lo_q <= req_addr[1:0];
                wait_cnt  <= '0;
            end
            if (state == ST_BUSY) begin
                if (ram_ack) begin
                    ram_req     <= 1'b0;
                    ram_we      <= 1'b0;
                    wait_cnt    <= '0;
                    rdata_valid <= ~ram_we;
                    if (!ram_we) rdata <= ld_ext;
                end else if (timeout) begin
                    ram_req  <= 1'b0;
                    ram_we   <= 1'b0;
                    wait_cnt <= '0;
                    rdata    <= '0;
                    bus_err  <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a load-data scoreboard queue.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misalign;
    logic        bus_err;
    logic        ram_req;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_ack;
    logic [31:0] ram_rdata;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    mem_access_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .misalign    (misalign),
        .bus_err     (bus_err),
        .ram_req     (ram_req),
        .ram_we      (ram_we),
        .ram_be      (ram_be),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_ack     (ram_ack),
        .ram_rdata   (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
    endtask

    // Full access with ack in BUSY cycle n (n>=1); checks the RAM port and completion.
    task automatic run_access(input string tag, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] word, input int unsigned n,
                              input logic [31:0] exp_data, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata);
        int unsigned k;
        logic [31:0] exp_v;
        @(negedge clk);
        drive_req(we, f3, addr, wd);
        if (!we) exp_q.push_back(exp_data);
        #1;
        chk({tag, ".stall_c0"}, 32'(stall), 32'd1);
        chk({tag, ".misalign"}, 32'(misalign), 32'd0);
        @(negedge clk); #1;
        chk({tag, ".ram_req"}, 32'(ram_req), 32'd1);
        chk({tag, ".ram_we"}, 32'(ram_we), 32'(we));
        chk({tag, ".ram_be"}, 32'(ram_be), 32'(exp_be));
        chk({tag, ".ram_addr"}, 32'(ram_addr), {2'b00, addr[31:2]});
        if (we) chk({tag, ".ram_wdata"}, ram_wdata, exp_wdata);
        for (int c = 2; c <= int'(n); c++) @(negedge clk);
        ram_ack   = 1'b1;
        ram_rdata = word;
        #1;
        chk({tag, ".stall_ack"}, 32'(stall), 32'd1);
        @(negedge clk);
        ram_ack   = 1'b0;
        req_valid = 1'b0;
        #1;
        chk({tag, ".stall_done"}, 32'(stall), 32'd0);
        chk({tag, ".ram_req_done"}, 32'(ram_req), 32'd0);
        chk({tag, ".bus_err"}, 32'(bus_err), 32'd0);
        if (we) begin
            chk({tag, ".rdata_valid"}, 32'(rdata_valid), 32'd0);
        end else begin
            k = 0;
            while (!rdata_valid && k < 8) begin
                @(negedge clk); #1;
                k++;
            end
            chk({tag, ".latency_extra"}, k, 32'd0);
            if (rdata_valid && exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                chk({tag, ".rdata"}, rdata, exp_v);
            end else begin
                chk({tag, ".rdata_seen"}, 32'(rdata_valid), 32'd1);
            end
        end
    endtask

    task automatic run_misalign(input string tag, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr);
        @(negedge clk);
        drive_req(we, f3, addr, 32'hDEAD_BEEF);
        #1;
        chk({tag, ".misalign"}, 32'(misalign), 32'd1);
        chk({tag, ".stall"}, 32'(stall), 32'd0);
        @(negedge clk); #1;
        chk({tag, ".ram_req"}, 32'(ram_req), 32'd0);
        req_valid = 1'b0;
    endtask

    initial begin
        int unsigned cnt;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; ram_ack = 1'b0; ram_rdata = '0;
        #12;
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.ram_req", 32'(ram_req), 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        chk("rst.rdata_valid", 32'(rdata_valid), 32'd0);
        chk("rst.bus_err", 32'(bus_err), 32'd0);
        chk("rst.ram_be", 32'(ram_be), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_access("lw100", 1'b0, 3'b010, 32'h100, '0, 32'h8000_00F0, 1, 32'h8000_00F0, 4'b1111, '0);
        run_access("lb103", 1'b0, 3'b000, 32'h103, '0, 32'h80AB_CDEF, 1, 32'hFFFF_FF80, 4'b1000, '0);
        run_access("lbu103", 1'b0, 3'b100, 32'h103, '0, 32'h80AB_CDEF, 2, 32'h0000_0080, 4'b1000, '0);
        run_access("lh102", 1'b0, 3'b001, 32'h102, '0, 32'h80AB_CDEF, 1, 32'hFFFF_80AB, 4'b1100, '0);
        run_access("lhu100", 1'b0, 3'b101, 32'h100, '0, 32'h80AB_CDEF, 3, 32'h0000_CDEF, 4'b0011, '0);
        run_access("lb101", 1'b0, 3'b000, 32'h101, '0, 32'h80AB_CDEF, 1, 32'hFFFF_FFCD, 4'b0010, '0);
        run_access("sb201", 1'b1, 3'b000, 32'h201, 32'h1234_5678, '0, 1, '0, 4'b0010, 32'h7878_7878);
        run_access("sh202", 1'b1, 3'b001, 32'h202, 32'h1234_5678, '0, 2, '0, 4'b1100, 32'h5678_5678);
        run_access("sw204", 1'b1, 3'b010, 32'h204, 32'h1234_5678, '0, 1, '0, 4'b1111, 32'h1234_5678);

        run_misalign("mis_lw102", 1'b0, 3'b010, 32'h102);
        run_misalign("mis_sh201", 1'b1, 3'b001, 32'h201);
        run_misalign("mis_f3_011", 1'b0, 3'b011, 32'h100);
        run_misalign("mis_st_bu", 1'b1, 3'b100, 32'h100);

        // ack while idle must not start or complete anything
        @(negedge clk);
        ram_ack = 1'b1;
        @(negedge clk); #1;
        chk("idle_ack.ram_req", 32'(ram_req), 32'd0);
        chk("idle_ack.rdata_valid", 32'(rdata_valid), 32'd0);
        ram_ack = 1'b0;

        // timeout: no ack at all
        @(negedge clk);
        drive_req(1'b0, 3'b010, 32'h300, '0);
        #1;
        chk("tmo.stall_c0", 32'(stall), 32'd1);
        @(negedge clk); #1;
        cnt = 0;
        while (ram_req && cnt < 20) begin
            cnt++;
            @(negedge clk); #1;
        end
        req_valid = 1'b0;
        chk("tmo.req_cycles", cnt, 32'd4);
        chk("tmo.bus_err", 32'(bus_err), 32'd1);
        chk("tmo.rdata", rdata, 32'd0);
        chk("tmo.stall", 32'(stall), 32'd0);
        @(negedge clk); #1;
        chk("tmo.bus_err_pulse", 32'(bus_err), 32'd0);

        run_access("ack4th", 1'b0, 3'b010, 32'h304, '0, 32'hCAFE_F00D, 4, 32'hCAFE_F00D, 4'b1111, '0);

        // reset during BUSY cycle 3
        @(negedge clk);
        drive_req(1'b0, 3'b010, 32'h400, '0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstb.ram_req", 32'(ram_req), 32'd0);
        chk("rstb.stall", 32'(stall), 32'd0);
        chk("rstb.ram_addr", 32'(ram_addr), 32'd0);
        chk("rstb.rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 1'b0;
        @(negedge clk); #1;
        chk("rstb.no_valid", 32'(rdata_valid), 32'd0);
        chk("rstb.no_err", 32'(bus_err), 32'd0);
        run_access("lw_after_rst", 1'b0, 3'b010, 32'h400, '0, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, 4'b1111, '0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
